// File: rtl/cp0_irq_ctrl_pkg.sv
// rtl/cp0_irq_ctrl_pkg.sv - CP0 op codes, register addresses and STATUS/CAUSE bit positions.
package cp0_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    EXE_CP_NONE   = 2'd0,
    EXE_CP_STORE  = 2'd1,
    EXE_CP0_ERET  = 2'd2,
    EXE_CP_RSVD   = 2'd3
  } cp0_oper_e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPCR   = 5'd14;
  localparam logic [4:0] CP0_EHBR   = 5'd15;

  localparam int STATUS_IE      = 0;
  localparam int STATUS_EXL     = 1;
  localparam int STATUS_IM_LSB  = 8;
  localparam int CAUSE_IP_LSB   = 8;
  localparam int CAUSE_LAST_LSB = 24;
  localparam int IDX_W          = 4;

endpackage

// File: rtl/cp0_irq_ctrl_prio_enc.sv
// rtl/cp0_irq_ctrl_prio_enc.sv - lowest-index-wins priority encoder (index, valid, one-hot).
import cp0_irq_ctrl_pkg::*;

module irq_prio_enc #(
  parameter int N = 8
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic [N-1:0]     onehot
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    idx    = '0;
    onehot = '0;
    valid  = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// rtl/cp0_irq_ctrl.sv - CP0 register file with multi-line edge-sticky interrupt controller.
// Define VECTORED_IRQ_EN to offset the handler address by the winning line index.
import cp0_irq_ctrl_pkg::*;

module cp0_irq_ctrl #(
  parameter int NUM_IRQ   = 8,
  parameter int VEC_SHIFT = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         oper,
  input  logic [4:0]         addr_r,
  output logic [31:0]        data_r,
  input  logic [4:0]         addr_w,
  input  logic [31:0]        data_w,
  input  logic               ir_en,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [31:0]        ret_addr,
  output logic               jump_en,
  output logic [31:0]        jump_addr,
  output logic [NUM_IRQ-1:0] irq_ack
);

  logic [NUM_IRQ-1:0] irq_q, pend, im;
  logic               ie, exl;
  logic [IDX_W-1:0]   last_irq;
  logic [31:0]        epc, ehbr;

  logic [NUM_IRQ-1:0] masked, win_onehot, pend_clr, pend_next;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid, take, do_store, do_eret;
  logic [31:0]        take_addr, status_val, cause_val;

  irq_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req    (masked),
    .idx    (win_idx),
    .valid  (win_valid),
    .onehot (win_onehot)
  );

  assign masked   = pend & im;
  assign take     = ir_en & ie & ~exl & win_valid;
  assign do_store = ir_en & ~take & (oper == EXE_CP_STORE);
  assign do_eret  = ir_en & ~take & (oper == EXE_CP0_ERET);

`ifdef VECTORED_IRQ_EN
  assign take_addr = ehbr + (32'(win_idx) << VEC_SHIFT);
`else
  assign take_addr = ehbr;
`endif

  // A fresh rising edge re-arms a line even if it is being cleared this cycle.
  always_comb begin
    pend_clr = take ? win_onehot : '0;
    if (do_store && addr_w == CP0_CAUSE)
      pend_clr = pend_clr | data_w[CAUSE_IP_LSB +: NUM_IRQ];
    pend_next = (pend & ~pend_clr) | (irq_in & ~irq_q);
  end

  always_comb begin
    status_val                             = '0;
    status_val[STATUS_IE]                  = ie;
    status_val[STATUS_EXL]                 = exl;
    status_val[STATUS_IM_LSB +: NUM_IRQ]   = im;
    cause_val                              = '0;
    cause_val[CAUSE_IP_LSB +: NUM_IRQ]     = pend;
    cause_val[CAUSE_LAST_LSB +: IDX_W]     = last_irq;
  end

  always_comb begin
    data_r = '0;
    case (addr_r)
      CP0_STATUS: data_r = status_val;
      CP0_CAUSE:  data_r = cause_val;
      CP0_EPCR:   data_r = epc;
      CP0_EHBR:   data_r = ehbr;
      default:    data_r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      pend      <= '0;
      im        <= '0;
      ie        <= 1'b0;
      exl       <= 1'b0;
      last_irq  <= '0;
      epc       <= '0;
      ehbr      <= '0;
      jump_en   <= 1'b0;
      jump_addr <= '0;
      irq_ack   <= '0;
    end else begin
      irq_q   <= irq_in;
      pend    <= pend_next;
      jump_en <= take | do_eret;
      irq_ack <= take ? win_onehot : '0;
      if (take) begin
        epc       <= ret_addr;
        exl       <= 1'b1;
        last_irq  <= win_idx;
        jump_addr <= take_addr;
      end else if (do_eret) begin
        exl       <= 1'b0;
        jump_addr <= epc;
      end else if (do_store) begin
        case (addr_w)
          CP0_STATUS: begin
            ie  <= data_w[STATUS_IE];
            exl <= data_w[STATUS_EXL];
            im  <= data_w[STATUS_IM_LSB +: NUM_IRQ];
          end
          CP0_EPCR: epc  <= data_w;
          CP0_EHBR: ehbr <= data_w;
          default: ;
        endcase
      end
    end
  end

endmodule
